// File: rtl/control_intersectie_pkg.sv
// Shared phase codes, approach indices and FSM state type for the intersection controller.
// The low three state bits are the phase code driven onto stare_semafor.
package pkg_intersectie;

  localparam logic [2:0] FAZA_N      = 3'b000;
  localparam logic [2:0] FAZA_E      = 3'b001;
  localparam logic [2:0] FAZA_V      = 3'b010;
  localparam logic [2:0] FAZA_S      = 3'b011;
  localparam logic [2:0] FAZA_ROSU   = 3'b100;
  localparam logic [2:0] FAZA_NOAPTE = 3'b111;

  localparam logic [1:0] IDX_N = 2'd0;
  localparam logic [1:0] IDX_E = 2'd1;
  localparam logic [1:0] IDX_V = 2'd2;
  localparam logic [1:0] IDX_S = 2'd3;

  // NIGHT and FAULT share phase code 111; the top bit tells them apart.
  typedef enum logic [3:0] {
    ST_VERDE_N = {1'b0, FAZA_N},
    ST_VERDE_E = {1'b0, FAZA_E},
    ST_VERDE_V = {1'b0, FAZA_V},
    ST_VERDE_S = {1'b0, FAZA_S},
    ST_ROSU    = {1'b0, FAZA_ROSU},
    ST_NOAPTE  = {1'b0, FAZA_NOAPTE},
    ST_DEFECT  = {1'b1, FAZA_NOAPTE}
  } stare_t;

  // Green state for an approach index; index and phase code coincide.
  function automatic stare_t stare_verde(input logic [1:0] idx);
    return stare_t'({2'b00, idx});
  endfunction

endpackage

// File: rtl/control_intersectie_arbitru.sv
// Combinational 4-way round-robin pick: first requesting approach after the last served one,
// or simply the next approach in rotation when nobody is requesting.
module arbitru_rr4 (
  input  logic [3:0] i_cerere,
  input  logic [1:0] i_ultim,
  output logic [1:0] o_urmator
);

  logic       w_gasit;
  logic [1:0] w_cand;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path infers a latch.
    o_urmator = i_ultim + 2'd1;
    w_gasit   = 1'b0;
    w_cand    = i_ultim;
    for (int k = 1; k <= 4; k++) begin
      w_cand = i_ultim + 2'(k);
      if (!w_gasit && i_cerere[w_cand]) begin
        o_urmator = w_cand;
        w_gasit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/control_intersectie.sv
// Central phase scheduler: round-robin green phases separated by all-red clearance,
// night flashing mode on request and an absorbing fault state on watchdog timeout.
module control_intersectie
  import pkg_intersectie::*;
#(
  parameter int CLEAR_TICKS   = 2,
  parameter int TIMEOUT_TICKS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] cerere,
  input  logic       ready_N,
  input  logic       ready_E,
  input  logic       ready_V,
  input  logic       ready_S,
  input  logic       mod_noapte,
  output logic [2:0] stare_semafor,
  output logic       start_faza,
  output logic       eroare
);

  localparam logic [3:0] LP_CLEAR   = 4'(CLEAR_TICKS);
  localparam logic [5:0] LP_TIMEOUT = 6'(TIMEOUT_TICKS);

  stare_t     r_stare;
  logic [3:0] r_cnt_clr;
  logic [5:0] r_cnt_wd;
  logic [1:0] r_ultim;
  logic       r_start_faza;
  logic       r_eroare;

  logic [1:0] w_urmator;
  logic [3:0] w_ready_vec;
  logic       w_ready_x;
  logic       w_clr_gata;
  logic       w_wd_gata;

  arbitru_rr4 u_arbitru (
    .i_cerere  (cerere),
    .i_ultim   (r_ultim),
    .o_urmator (w_urmator)
  );

  // Only the ready of the approach currently green matters; index equals phase code.
  assign w_ready_vec = {ready_S, ready_V, ready_E, ready_N};
  assign w_ready_x   = w_ready_vec[r_stare[1:0]];

  assign w_clr_gata  = tick && ((r_cnt_clr + 4'd1) == LP_CLEAR);
  assign w_wd_gata   = tick && ((r_cnt_wd + 6'd1) == LP_TIMEOUT);

  // NOTE: non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stare      <= ST_ROSU;
      r_cnt_clr    <= 4'd0;
      r_cnt_wd     <= 6'd0;
      r_ultim      <= IDX_S;
      r_start_faza <= 1'b0;
      r_eroare     <= 1'b0;
    end else begin
      r_start_faza <= 1'b0;
      case (r_stare)
        ST_ROSU: begin
          if (w_clr_gata) begin
            r_cnt_clr <= 4'd0;
            if (mod_noapte) begin
              r_stare <= ST_NOAPTE;
            end else begin
              r_stare      <= stare_verde(w_urmator);
              r_start_faza <= 1'b1;
              r_cnt_wd     <= 6'd0;
            end
          end else if (tick) begin
            r_cnt_clr <= r_cnt_clr + 4'd1;
          end
        end

        ST_VERDE_N, ST_VERDE_E, ST_VERDE_V, ST_VERDE_S: begin
          // Ready is checked first so it wins over a simultaneous timeout.
          if (w_ready_x) begin
            r_stare   <= ST_ROSU;
            r_ultim   <= r_stare[1:0];
            r_cnt_wd  <= 6'd0;
            r_cnt_clr <= 4'd0;
          end else if (w_wd_gata) begin
            r_stare  <= ST_DEFECT;
            r_eroare <= 1'b1;
            r_cnt_wd <= 6'd0;
          end else if (tick) begin
            r_cnt_wd <= r_cnt_wd + 6'd1;
          end
        end

        ST_NOAPTE: begin
          if (!mod_noapte) begin
            r_stare   <= ST_ROSU;
            r_cnt_clr <= 4'd0;
          end
        end

        ST_DEFECT: begin
          r_eroare <= 1'b1;
        end

        default: begin
          r_stare   <= ST_ROSU;
          r_cnt_clr <= 4'd0;
          r_cnt_wd  <= 6'd0;
        end
      endcase
    end
  end

  assign stare_semafor = r_stare[2:0];
  assign start_faza    = r_start_faza;
  assign eroare        = r_eroare;

endmodule

// File: tb/tb_control_intersectie.sv
// Bench for control_intersectie: directed vector table, hand sequences for timeout,
// fault and asynchronous reset, then random stimulus against a behavioural model.
module tb_control_intersectie;

  localparam int CLEAR   = 2;
  localparam int TIMEOUT = 5;

  localparam int MODE_RED   = 4;
  localparam int MODE_NIGHT = 5;
  localparam int MODE_FAULT = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] cerere = 4'd0;
  logic       ready_N = 1'b0, ready_E = 1'b0, ready_V = 1'b0, ready_S = 1'b0;
  logic       mod_noapte = 1'b0;
  logic [2:0] stare_semafor;
  logic       start_faza;
  logic       eroare;

  int n_checks = 0;
  int n_errors = 0;

  control_intersectie #(.CLEAR_TICKS(CLEAR), .TIMEOUT_TICKS(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .cerere        (cerere),
    .ready_N       (ready_N),
    .ready_E       (ready_E),
    .ready_V       (ready_V),
    .ready_S       (ready_S),
    .mod_noapte    (mod_noapte),
    .stare_semafor (stare_semafor),
    .start_faza    (start_faza),
    .eroare        (eroare)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode is the green approach (0..3) or RED/NIGHT/FAULT.
  int m_mode, m_clr, m_wd, m_last;
  bit m_start, m_err;

  task automatic model_reset();
    m_mode = MODE_RED; m_clr = 0; m_wd = 0; m_last = 3; m_start = 0; m_err = 0;
  endtask

  function automatic int pick_next(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++)
      if (req[(last + k) % 4]) return (last + k) % 4;
    return (last + 1) % 4;
  endfunction

  function automatic logic [2:0] exp_code();
    if (m_mode < 4) return 3'(m_mode);
    if (m_mode == MODE_RED) return 3'b100;
    return 3'b111;
  endfunction

  task automatic model_edge();
    logic [3:0] rdy;
    rdy = {ready_S, ready_V, ready_E, ready_N};
    m_start = 1'b0;
    if (m_mode < 4) begin
      if (rdy[m_mode]) begin
        m_last = m_mode;
        m_mode = MODE_RED;
      end else if (tick) begin
        m_wd++;
        if (m_wd == TIMEOUT) begin m_mode = MODE_FAULT; m_err = 1'b1; end
      end
    end else if (m_mode == MODE_RED) begin
      if (tick) begin
        m_clr++;
        if (m_clr == CLEAR) begin
          m_clr = 0;
          if (mod_noapte) m_mode = MODE_NIGHT;
          else begin m_mode = pick_next(cerere, m_last); m_start = 1'b1; m_wd = 0; end
        end
      end
    end else if (m_mode == MODE_NIGHT) begin
      if (!mod_noapte) begin m_mode = MODE_RED; m_clr = 0; end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge; leaves time 1 unit after the edge so outputs are settled.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic t, input logic [3:0] req, input logic [3:0] rdy, input logic n);
    tick = t; cerere = req; mod_noapte = n;
    {ready_S, ready_V, ready_E, ready_N} = rdy;
  endtask

  task automatic do_reset();
    set_in(1'b0, 4'd0, 4'd0, 1'b0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       tick;
    logic [3:0] cerere;
    logic [3:0] rdy;     // {S,V,E,N}
    logic       noapte;
    logic [2:0] e_stare;
    logic       e_start;
    logic       e_err;
  } vec_t;

  function automatic vec_t mk(input logic t, input logic [3:0] req, input logic [3:0] rdy,
                              input logic n, input logic [2:0] st, input logic sf, input logic er);
    vec_t v;
    v.tick = t; v.cerere = req; v.rdy = rdy; v.noapte = n;
    v.e_stare = st; v.e_start = sf; v.e_err = er;
    return v;
  endfunction

  vec_t tabel [27];

  initial begin
    tabel[0]  = mk(1, 4'b0000, 4'b0000, 0, 3'b100, 0, 0);
    tabel[1]  = mk(1, 4'b0000, 4'b0000, 0, 3'b000, 1, 0);
    tabel[2]  = mk(0, 4'b0000, 4'b0000, 0, 3'b000, 0, 0);
    tabel[3]  = mk(1, 4'b0000, 4'b0000, 0, 3'b000, 0, 0);
    tabel[4]  = mk(0, 4'b0000, 4'b0010, 0, 3'b000, 0, 0);
    tabel[5]  = mk(0, 4'b0000, 4'b0001, 0, 3'b100, 0, 0);
    tabel[6]  = mk(1, 4'b0000, 4'b0000, 0, 3'b100, 0, 0);
    tabel[7]  = mk(1, 4'b0000, 4'b0000, 0, 3'b001, 1, 0);
    tabel[8]  = mk(0, 4'b0000, 4'b0010, 0, 3'b100, 0, 0);
    tabel[9]  = mk(1, 4'b0100, 4'b0000, 0, 3'b100, 0, 0);
    tabel[10] = mk(1, 4'b0100, 4'b0000, 0, 3'b010, 1, 0);
    tabel[11] = mk(0, 4'b0100, 4'b0100, 0, 3'b100, 0, 0);
    tabel[12] = mk(1, 4'b0100, 4'b0000, 0, 3'b100, 0, 0);
    tabel[13] = mk(1, 4'b0100, 4'b0000, 0, 3'b010, 1, 0);
    tabel[14] = mk(0, 4'b0100, 4'b0100, 0, 3'b100, 0, 0);
    tabel[15] = mk(1, 4'b0000, 4'b0000, 0, 3'b100, 0, 0);
    tabel[16] = mk(1, 4'b0000, 4'b0000, 0, 3'b011, 1, 0);
    tabel[17] = mk(0, 4'b0000, 4'b1000, 0, 3'b100, 0, 0);
    tabel[18] = mk(1, 4'b1001, 4'b0000, 0, 3'b100, 0, 0);
    tabel[19] = mk(1, 4'b1001, 4'b0000, 0, 3'b000, 1, 0);
    tabel[20] = mk(1, 4'b0000, 4'b0001, 0, 3'b100, 0, 0);
    tabel[21] = mk(1, 4'b0000, 4'b0000, 1, 3'b100, 0, 0);
    tabel[22] = mk(1, 4'b0000, 4'b0000, 1, 3'b111, 0, 0);
    tabel[23] = mk(1, 4'b0000, 4'b0000, 1, 3'b111, 0, 0);
    tabel[24] = mk(0, 4'b0000, 4'b0000, 0, 3'b100, 0, 0);
    tabel[25] = mk(1, 4'b0000, 4'b0000, 0, 3'b100, 0, 0);
    tabel[26] = mk(1, 4'b0000, 4'b0000, 0, 3'b001, 1, 0);

    model_reset();
    #12;
    rst = 1'b1;
    #1;
    check("reset stare", stare_semafor, 3'b100);
    check("reset start", start_faza, 1'b0);
    check("reset eroare", eroare, 1'b0);

    // Directed table from reset.
    for (int i = 0; i < 27; i++) begin
      set_in(tabel[i].tick, tabel[i].cerere, tabel[i].rdy, tabel[i].noapte);
      step();
      check($sformatf("vec%0d stare", i), stare_semafor, tabel[i].e_stare);
      check($sformatf("vec%0d start", i), start_faza, tabel[i].e_start);
      check($sformatf("vec%0d eroare", i), eroare, tabel[i].e_err);
    end

    // Ready arriving on the same edge as the timeout tick wins.
    do_reset();
    set_in(1, 4'b0000, 4'b0000, 0);
    step(); step();
    check("tie enter N", stare_semafor, 3'b000);
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    check("tie before limit", stare_semafor, 3'b000);
    set_in(1, 4'b0000, 4'b0001, 0);
    step();
    check("tie stare", stare_semafor, 3'b100);
    check("tie eroare", eroare, 1'b0);

    // Timeout in GREEN_E leads to a sticky fault.
    set_in(1, 4'b0000, 4'b0000, 0);
    step(); step();
    check("to enter E", stare_semafor, 3'b001);
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    check("to 4th tick", stare_semafor, 3'b001);
    check("to 4th eroare", eroare, 1'b0);
    step();
    check("to 5th stare", stare_semafor, 3'b111);
    check("to 5th eroare", eroare, 1'b1);
    for (int i = 0; i < 20; i++) begin
      set_in(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'b1111, 1'(i % 2));
      step();
    end
    check("fault held stare", stare_semafor, 3'b111);
    check("fault held eroare", eroare, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async rst eroare", eroare, 1'b0);
    check("async rst stare", stare_semafor, 3'b100);
    #2;
    rst = 1'b1;

    // Asynchronous reset during the first cycle of GREEN_V.
    model_reset();
    set_in(1, 4'b0100, 4'b0000, 0);
    step(); step();
    check("v enter stare", stare_semafor, 3'b010);
    check("v enter start", start_faza, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("rst midV stare", stare_semafor, 3'b100);
    check("rst midV start", start_faza, 1'b0);
    check("rst midV eroare", eroare, 1'b0);
    #2;
    rst = 1'b1;
    set_in(1, 4'b0000, 4'b0000, 0);
    step(); step();
    check("after rst N first", stare_semafor, 3'b000);

    // Random stimulus against the model.
    do_reset();
    begin
      int fault_age;
      fault_age = 0;
      for (int c = 0; c < 3000; c++) begin
        fault_age = (m_mode == MODE_FAULT) ? fault_age + 1 : 0;
        if (fault_age > 6 || $urandom_range(0, 499) == 0) begin
          do_reset();
          fault_age = 0;
        end
        tick    = ($urandom_range(0, 1) == 1);
        cerere  = 4'($urandom_range(0, 15));
        ready_N = ($urandom_range(0, 3) == 0);
        ready_E = ($urandom_range(0, 3) == 0);
        ready_V = ($urandom_range(0, 3) == 0);
        ready_S = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 39) == 0) mod_noapte = ~mod_noapte;
        step();
        check("rnd stare", stare_semafor, exp_code());
        check("rnd start", start_faza, m_start);
        check("rnd eroare", eroare, m_err);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_intersectie.md
Name: control_intersectie

Overview:
- Central phase scheduler for the four-approach signalised intersection.
- Drives the shared `stare_semafor` bus consumed by the NORD, EST, SUD and VEST light modules.
- Grants green phases round-robin among approaches with pending demand, inserting an all-red clearance interval between phases.
- Waits for each approach's `ready` completion handshake, switches to flashing-yellow night mode on request, and falls back to flashing-yellow on a watchdog timeout.

Parameters:
- CLEAR_TICKS, 2: all-red clearance length, in `tick` strobes. Legal range 1..15; 0 is illegal.
- TIMEOUT_TICKS, 40: maximum `tick` strobes allowed in a green phase before a fault is declared. Legal range 1..63.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- tick  in  1  one-clk-wide timebase strobe, from the clock divider
- cerere  in  4  per-approach demand, level; bit0=N, bit1=E, bit2=V, bit3=S
- ready_N, ready_E, ready_V, ready_S  in  1 each  phase-complete handshake from each light module
- mod_noapte  in  1  night-mode request, level
- stare_semafor  out  3  phase code driven to all light modules
- start_faza  out  1  one-clk pulse on entry to any green phase
- eroare  out  1  sticky watchdog fault flag

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is asynchronous and active-low.
- Reset values:
  - stare_semafor = 3'b100 (ALL_RED)
  - start_faza = 0
  - eroare = 0
  - clearance counter = 0
  - watchdog counter = 0
  - last-served pointer = S (so N is served first)
  - FSM in ALL_RED
- Phase codes: N=3'b000, E=3'b001, V=3'b010, S=3'b011, ALL_RED=3'b100, NIGHT/FAULT=3'b111. Codes 101 and 110 are never driven.
- `stare_semafor` is a registered output and equals the FSM state encoding.
- FSM states: ALL_RED, GREEN_N, GREEN_E, GREEN_V, GREEN_S, NIGHT, FAULT.
- ALL_RED:
  - Counts `tick` strobes.
  - When the count reaches CLEAR_TICKS, on that same clk edge: if `mod_noapte`=1, go to NIGHT; otherwise go to the selected next green state.
  - The clearance counter is cleared on exit.
- Next-green selection, round-robin:
  - Search order is N, E, V, S, cyclic, starting at the approach after last-served.
  - Pick the first approach whose `cerere` bit is set.
  - If `cerere`=0, take the approach immediately after last-served (fixed rotation, no phase skipped).
  - `cerere` is sampled only on the ALL_RED exit edge.
- GREEN_x:
  - `start_faza`=1 in the first clk cycle of the state.
  - Watchdog counter cleared on entry and incremented per `tick`.
  - Only the matching `ready_x` is honoured; the other three ready inputs are ignored.
  - `ready_x`=1 on any clk edge: go to ALL_RED and update last-served to x.
  - Watchdog reaches TIMEOUT_TICKS with no ready: go to FAULT and set `eroare`=1.
  - `ready_x` and timeout on the same edge: ready wins, no fault.
- `mod_noapte` asserted during a green phase is not acted on until the next ALL_RED exit. The running phase always completes.
- NIGHT:
  - Holds 3'b111.
  - When `mod_noapte` samples 0, go to ALL_RED with a full CLEAR_TICKS clearance.
  - Last-served is unchanged.
- FAULT:
  - Holds 3'b111 with `eroare`=1.
  - Absorbing; exit only via `rst`.
- Reset asserted mid-phase: all state returns to the reset values immediately (asynchronous). No ready handshake is required on exit.
- Counter widths: clearance counter 4 bits, watchdog counter 6 bits. Counters never wrap; they are compared with equality and cleared on state exit.
- Any unreachable state recovers to ALL_RED.

Decomposition:
- Shared package `pkg_intersectie` holds:
  - phase-code constants FAZA_N, FAZA_E, FAZA_V, FAZA_S, FAZA_ROSU, FAZA_NOAPTE
  - the approach index constants, N=0 E=1 V=2 S=3
- One natural sub-module, `arbitru_rr4`: a combinational 4-way round-robin pick. Inputs are the `cerere` vector and the last-served index. Output is the 2-bit next index; when `cerere`=0 it outputs last+1.
- The FSM, counters and watchdog remain in `control_intersectie`.

Test Plan:
- Reset release, `cerere`=4'b0000, CLEAR_TICKS=2, each ready pulsed 3 ticks after phase entry -> `stare_semafor` sequence 100, 000, 100, 001, 100, 010, 100, 011, 100, 000. `start_faza` pulses once at each green entry.
- `cerere`=4'b0100 (V only), held -> phases alternate 100, 010, 100, 010. N, E and S are never granted.
- During GREEN_E, pulse ready_N and ready_V -> no transition. A following ready_E -> 100 on the next edge, and after 2 ticks 010 if `cerere`=4'b0100.
- `mod_noapte`=1 asserted mid GREEN_N -> GREEN_N continues until ready_N, then 100 for 2 ticks, then 111. Deassert `mod_noapte` -> 100 for 2 ticks, then 001.
- TIMEOUT_TICKS=5, no ready in GREEN_S -> after the 5th tick `stare_semafor`=111 and `eroare`=1. Both remain through later `mod_noapte`, `cerere` and ready activity until `rst`=0.
- `rst` driven low asynchronously mid GREEN_V between clk edges -> `stare_semafor`=100, `eroare`=0 and `start_faza`=0 without waiting for a clk edge. After release, N is served first.
